// File: rtl/bcd_calc_ctrl.sv
// Keypad sequencer for a 3-digit BCD subtractor: collects A and B, waits one
// settle cycle in EVAL, then latches difference and sign for the display.
module bcd_calc_ctrl #(
  parameter logic [3:0] KEY_MINUS = 4'hA,
  parameter logic [3:0] KEY_EQ    = 4'hB,
  parameter logic [3:0] KEY_CLR   = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] sub_a_ones,
  output logic [3:0] sub_a_tens,
  output logic [3:0] sub_a_huns,
  output logic [3:0] sub_b_ones,
  output logic [3:0] sub_b_tens,
  output logic [3:0] sub_b_huns,
  input  logic [3:0] sub_out_ones,
  input  logic [3:0] sub_out_tens,
  input  logic [3:0] sub_out_huns,
  input  logic       sub_negative,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_huns,
  output logic       disp_neg,
  output logic       done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EVAL    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic        neg_q, neg_d, disp_neg_q, disp_neg_d, done_q, done_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        accept, is_digit;
  logic [11:0] sub_out;

  assign sub_out  = {sub_out_huns, sub_out_tens, sub_out_ones};
  assign accept   = key_valid && (state_q != EVAL);
  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    disp_d     = disp_q;
    disp_neg_d = 1'b0;

    if (accept && key_code == KEY_CLR) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      neg_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (accept && is_digit && cnt_q != 2'd3) begin
            a_d   = {a_q[7:0], key_code};
            cnt_d = cnt_q + 2'd1;
          end else if (accept && key_code == KEY_MINUS) begin
            state_d = ENTER_B;
            b_d     = '0;
            cnt_d   = '0;
          end
        end
        ENTER_B: begin
          if (accept && is_digit && cnt_q != 2'd3) begin
            b_d   = {b_q[7:0], key_code};
            cnt_d = cnt_q + 2'd1;
          end else if (accept && key_code == KEY_EQ) begin
            state_d = EVAL;
          end
        end
        EVAL: begin
          // bcd_sub reports equal operands as negative; zero never shows a minus.
          state_d = SHOW;
          res_d   = sub_out;
          neg_d   = sub_negative && (sub_out != 12'h000);
          done_d  = 1'b1;
        end
        SHOW: begin
          if (accept && is_digit) begin
            state_d = ENTER_A;
            a_d     = {8'h00, key_code};
            b_d     = '0;
            cnt_d   = 2'd1;
          end else if (accept && key_code == KEY_MINUS && !neg_q) begin
            state_d = ENTER_B;
            a_d     = res_q;
            b_d     = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end

    // Display follows the next state so it tracks the registers it mirrors.
    case (state_d)
      ENTER_A: disp_d = a_d;
      ENTER_B: disp_d = b_d;
      default: begin
        disp_d     = res_d;
        disp_neg_d = neg_d;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      disp_q     <= disp_d;
      disp_neg_q <= disp_neg_d;
    end
  end

  assign key_ready  = (state_q != EVAL);
  assign state_dbg  = state_q;
  assign done       = done_q;
  assign sub_a_huns = a_q[11:8];
  assign sub_a_tens = a_q[7:4];
  assign sub_a_ones = a_q[3:0];
  assign sub_b_huns = b_q[11:8];
  assign sub_b_tens = b_q[7:4];
  assign sub_b_ones = b_q[3:0];
  assign disp_huns  = disp_q[11:8];
  assign disp_tens  = disp_q[7:4];
  assign disp_ones  = disp_q[3:0];
  assign disp_neg   = disp_neg_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Scoreboard bench for bcd_calc_ctrl: integer-level calculator model, a
// behavioural bcd_sub, and a monitor that checks every done pulse.
module tb_bcd_calc_ctrl;

  localparam logic [3:0] K_MINUS = 4'hA;
  localparam logic [3:0] K_EQ    = 4'hB;
  localparam logic [3:0] K_CLR   = 4'hC;

  logic       clk, rst, key_valid, key_ready, sub_negative, disp_neg, done;
  logic [3:0] key_code;
  logic [3:0] sub_a_ones, sub_a_tens, sub_a_huns;
  logic [3:0] sub_b_ones, sub_b_tens, sub_b_huns;
  logic [3:0] sub_out_ones, sub_out_tens, sub_out_huns;
  logic [3:0] disp_ones, disp_tens, disp_huns;
  logic [1:0] state_dbg;

  bcd_calc_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready),
    .sub_a_ones(sub_a_ones), .sub_a_tens(sub_a_tens), .sub_a_huns(sub_a_huns),
    .sub_b_ones(sub_b_ones), .sub_b_tens(sub_b_tens), .sub_b_huns(sub_b_huns),
    .sub_out_ones(sub_out_ones), .sub_out_tens(sub_out_tens),
    .sub_out_huns(sub_out_huns), .sub_negative(sub_negative),
    .disp_ones(disp_ones), .disp_tens(disp_tens), .disp_huns(disp_huns),
    .disp_neg(disp_neg), .done(done), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dec3(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    return int'(h) * 100 + int'(t) * 10 + int'(o);
  endfunction

  // Behavioural bcd_sub: magnitude of A-B, equal operands flagged negative.
  int env_av, env_bv, env_d;
  always_comb begin
    env_av = dec3(sub_a_huns, sub_a_tens, sub_a_ones);
    env_bv = dec3(sub_b_huns, sub_b_tens, sub_b_ones);
    if (env_av > env_bv) begin
      env_d        = env_av - env_bv;
      sub_negative = 1'b0;
    end else begin
      env_d        = env_bv - env_av;
      sub_negative = 1'b1;
    end
    sub_out_huns = 4'((env_d / 100) % 10);
    sub_out_tens = 4'((env_d / 10) % 10);
    sub_out_ones = 4'(env_d % 10);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int res;
    int neg;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // Calculator model: 0=entering A, 1=entering B, 2=evaluating, 3=showing.
  int m_st = 0, ma = 0, mb = 0, mres = 0, mneg = 0, mcnt = 0;

  task automatic model_step(input bit r, input bit v, input logic [3:0] c);
    exp_t e;
    if (r) begin
      m_st = 0; ma = 0; mb = 0; mres = 0; mneg = 0; mcnt = 0;
    end else if (m_st == 2) begin
      mres = (ma >= mb) ? ma - mb : mb - ma;
      mneg = (ma < mb) ? 1 : 0;
      e.res = mres; e.neg = mneg; e.cyc = pe + 1;
      sb.push_back(e);
      m_st = 3;
    end else if (v) begin
      if (c == K_CLR) begin
        m_st = 0; ma = 0; mb = 0; mres = 0; mneg = 0; mcnt = 0;
      end else if (c <= 4'd9) begin
        if (m_st == 3) begin
          ma = int'(c); mb = 0; mcnt = 1; m_st = 0;
        end else if (mcnt < 3) begin
          if (m_st == 0) ma = (ma * 10 + int'(c)) % 1000;
          else           mb = (mb * 10 + int'(c)) % 1000;
          mcnt++;
        end
      end else if (c == K_MINUS) begin
        if (m_st == 0) begin
          m_st = 1; mb = 0; mcnt = 0;
        end else if (m_st == 3 && mneg == 0) begin
          ma = mres; mb = 0; mcnt = 0; m_st = 1;
        end
      end else if (c == K_EQ && m_st == 1) begin
        m_st = 2;
      end
    end
  endtask

  task automatic check_outputs();
    chk("state_dbg", int'(state_dbg), m_st);
    chk("key_ready", int'(key_ready), (m_st != 2) ? 1 : 0);
    chk("sub_a", dec3(sub_a_huns, sub_a_tens, sub_a_ones), ma);
    chk("sub_b", dec3(sub_b_huns, sub_b_tens, sub_b_ones), mb);
    chk("disp", dec3(disp_huns, disp_tens, disp_ones),
        (m_st == 0) ? ma : (m_st == 1) ? mb : mres);
    chk("disp_neg", int'(disp_neg), (m_st >= 2) ? mneg : 0);
  endtask

  // One clock of stimulus: check what the previous edge produced, then drive.
  task automatic cycle(input bit r, input bit v, input logic [3:0] c);
    @(negedge clk);
    check_outputs();
    rst = r; key_valid = v; key_code = c;
    model_step(r, v, c);
  endtask

  task automatic send_key(input logic [3:0] c);
    cycle(1'b0, 1'b1, c);
    cycle(1'b0, 1'b0, 4'h0);
  endtask

  task automatic send_seq(input logic [3:0] s[$]);
    foreach (s[i]) send_key(s[i]);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", pe, e.cyc);
        chk("result", dec3(disp_huns, disp_tens, disp_ones), e.res);
        chk("result_neg", int'(disp_neg), e.neg);
      end
    end
  end

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);

    send_seq('{4'd5, 4'd2, 4'd7, K_MINUS, 4'd1, 4'd3, 4'd9, K_EQ});
    send_seq('{K_CLR, 4'd4, 4'd5, K_MINUS, 4'd1, 4'd2, 4'd0, K_EQ, K_MINUS, K_EQ});
    send_seq('{K_CLR, 4'd3, 4'd3, 4'd3, K_MINUS, 4'd3, 4'd3, 4'd3, K_EQ});
    send_seq('{4'd9, 4'd9, 4'd9, 4'd8, K_MINUS, 4'd1, K_EQ});
    send_seq('{K_MINUS, 4'd9, 4'd9, K_EQ});
    send_seq('{4'hD, 4'hE, 4'hF, K_EQ});

    // Strobe on the EVAL cycle is dropped, then clear from SHOW.
    send_seq('{4'd1, K_MINUS, 4'd2});
    cycle(1'b0, 1'b1, K_EQ);
    cycle(1'b0, 1'b1, 4'd7);
    cycle(1'b0, 1'b0, 4'h0);
    send_key(K_CLR);

    // Reset on the EVAL cycle: no done pulse, everything back to zero.
    send_seq('{4'd8, K_MINUS, 4'd3});
    cycle(1'b0, 1'b1, K_EQ);
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    // Reset wins over a simultaneous key.
    cycle(1'b1, 1'b1, 4'd6);
    cycle(1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'h0);
    chk("pending_results", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_calc_ctrl.md
Name: bcd_calc_ctrl

Overview:
- Keypad-driven sequencer for the 3-digit BCD subtract datapath.
- Collects operand A, then operand B, digit by digit; presents both to an external bcd_sub instance; waits one settle cycle; registers the difference and sign for display.
- Supports chaining: a non-negative result can become the next A.
- Sits between the debounced keypad decoder and the 7-segment display driver.

Parameters:
- KEY_MINUS, 4'hA, key code that ends A entry and starts B entry
- KEY_EQ, 4'hB, key code that triggers evaluation
- KEY_CLR, 4'hC, key code for global clear

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 = digit; KEY_MINUS/KEY_EQ/KEY_CLR = commands; other codes ignored
- key_ready  out  1  high when a key strobe will be accepted
- sub_a_ones, sub_a_tens, sub_a_huns  out  4 each  operand A to bcd_sub
- sub_b_ones, sub_b_tens, sub_b_huns  out  4 each  operand B to bcd_sub
- sub_out_ones, sub_out_tens, sub_out_huns  in  4 each  bcd_sub magnitude
- sub_negative  in  1  bcd_sub sign
- disp_ones, disp_tens, disp_huns  out  4 each  digits to display driver
- disp_neg  out  1  minus-sign segment
- done  out  1  one-cycle pulse when a result is latched
- state_dbg  out  2  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - State ENTER_A (2'd0).
  - A, B, result registers, digit counter, disp_*, disp_neg, done: all 0.
  - key_ready = 1.
- States and encoding: ENTER_A=0, ENTER_B=1, EVAL=2, SHOW=3. key_ready = (state != EVAL).
- A key is accepted only when key_valid=1 and key_ready=1.
  - Keys during EVAL are dropped, not queued.
  - Codes 4'hD-4'hF are ignored in every state.
- Digit entry, ENTER_A or ENTER_B:
  - Shift left: huns<=tens, tens<=ones, ones<=digit.
  - Per-operand count increments, saturating at 3.
  - A digit arriving when count==3 is ignored (operand unchanged).
- Transitions:
  - ENTER_A + KEY_MINUS -> ENTER_B: B cleared to 000, count cleared.
  - ENTER_A + KEY_EQ: ignored.
  - ENTER_B + KEY_MINUS: ignored.
  - ENTER_B + KEY_EQ -> EVAL.
  - EVAL -> SHOW unconditionally after exactly one cycle. On that edge, the result registers capture sub_out_* and the sign, and done=1 for that one cycle.
  - SHOW + digit -> ENTER_A: A = 00d, count=1, B = 000.
  - SHOW + KEY_MINUS, result sign=0 -> ENTER_B: A = result, B = 000, count=0.
  - SHOW + KEY_MINUS, result sign=1: ignored (no negative chaining).
  - SHOW + KEY_EQ: ignored.
  - KEY_CLR in ENTER_A, ENTER_B or SHOW -> ENTER_A next cycle, with A, B, result, counts and sign all 0.
- Latency: KEY_EQ accepted at edge N -> EVAL after N; result registers and done valid after edge N+1.
- Sign rule: latched sign = sub_negative AND (sub_out != 000). bcd_sub flags equal operands as negative; a zero result must never show a minus sign.
- Operand outputs: sub_a_* and sub_b_* are driven directly from the A and B registers at all times and are stable through EVAL.
- Display:
  - ENTER_A: shows A, disp_neg=0.
  - ENTER_B: shows B, disp_neg=0.
  - EVAL and SHOW: show the result registers and the latched sign.
  - All display outputs are registered.
- Reset asserted in any state, including EVAL: next state ENTER_A, no done pulse, result not latched.
- Simultaneous rst and key_valid: rst wins; the key is lost.

Test Plan:
- Basic subtract: keys 5,2,7, A, 1,3,9, B -> done pulses exactly 2 cycles after the B strobe; disp=388, disp_neg=0.
- Negative result: keys 4,5, A, 1,2,0, B -> disp=075, disp_neg=1. Then key A -> ignored; state_dbg stays 3.
- Equal operands: 3,3,3, A, 3,3,3, B -> disp=000, disp_neg=0, although sub_negative=1 is fed to the controller.
- Saturation and chaining: keys 9,9,9,8 -> A=999 (4th digit ignored). Then A, 1, B -> 998. Then A, 9,9, B -> 899.
- Drop and clear: key strobe during EVAL -> ignored. KEY_CLR in SHOW -> next cycle all outputs 0, state 0.
- Reset mid-EVAL: assert rst on the EVAL cycle -> no done pulse; disp=000; state_dbg=0; key_ready=1.
